// File: rtl/cnn_pkg.sv
// Shared definitions for the sliding-window generator: default geometry,
// derived sizes and the window element index helper.
package cnn_pkg;

    localparam int DEF_IMG_W  = 28;
    localparam int DEF_IMG_H  = 28;
    localparam int DEF_KX     = 5;
    localparam int DEF_KY     = 5;
    localparam int DEF_I_F_BW = 8;

    localparam int WIN_PER_FRAME = (DEF_IMG_W - DEF_KX + 1) * (DEF_IMG_H - DEF_KY + 1);
    localparam int COL_W         = $clog2(DEF_IMG_W);
    localparam int ROW_W         = $clog2(DEF_IMG_H);

    // Flattened position of window element (row k, column j); row 0 is the oldest line.
    function automatic int idx(input int k, input int j, input int kx = DEF_KX);
        return k * kx + j;
    endfunction

endpackage

// File: rtl/cnn_line_buffer.sv
// One image line of storage. The read is combinational on the current column,
// so the old value is seen in the same cycle the new pixel overwrites it.
module cnn_line_buffer #(
    parameter int DEPTH  = 28,
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wr_data,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    assign rd_data = mem[addr];

    // Store the incoming value at the current column; contents are never cleared.
    always_ff @(posedge clk) begin
        if (en) begin
            mem[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/cnn_window_gen.sv
// Turns a raster pixel stream into KX x KY stride-1 windows. KY-1 chained line
// buffers supply the older rows of each new right-hand column; a window is
// emitted once enough rows and columns of the current frame have arrived.
module cnn_window_gen
    import cnn_pkg::*;
#(
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H,
    parameter int KX     = DEF_KX,
    parameter int KY     = DEF_KY,
    parameter int I_F_BW = DEF_I_F_BW
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_in_valid,
    input  logic [I_F_BW-1:0]        i_in_pixel,
    output logic                     o_ot_valid,
    output logic [KX*KY*I_F_BW-1:0]  o_ot_fmap,
    output logic                     o_ot_frame_done
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    localparam logic [CW-1:0] COL_LAST      = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST      = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_FIRST_WIN = CW'(KX - 1);
    localparam logic [RW-1:0] ROW_FIRST_WIN = RW'(KY - 1);

    logic [CW-1:0]             col_cnt;
    logic [RW-1:0]             row_cnt;
    logic [I_F_BW-1:0]         win     [KY][KX];
    logic [I_F_BW-1:0]         win_nxt [KY][KX];
    logic [I_F_BW-1:0]         lb_rd   [KY-1];
    logic [I_F_BW-1:0]         lb_wr   [KY-1];
    logic [KX*KY*I_F_BW-1:0]   fmap_nxt;
    logic                      accept;
    logic                      col_wrap;
    logic                      last_px;
    logic                      emit;

    // Reset wins over a simultaneous pixel, so that pixel must not touch the lines either.
    assign accept   = i_in_valid & ~reset;
    assign col_wrap = (col_cnt == COL_LAST);
    assign last_px  = col_wrap && (row_cnt == ROW_LAST);
    assign emit     = (row_cnt >= ROW_FIRST_WIN) && (col_cnt >= COL_FIRST_WIN);

    // Buffer 0 holds the previous row; each further buffer is one row older.
    generate
        for (genvar i = 0; i < KY - 1; i++) begin : g_line
            if (i == 0) begin : g_head
                assign lb_wr[i] = i_in_pixel;
            end else begin : g_tail
                assign lb_wr[i] = lb_rd[i-1];
            end
            cnn_line_buffer #(
                .DEPTH  (IMG_W),
                .WIDTH  (I_F_BW),
                .ADDR_W (CW)
            ) u_line (
                .clk     (clk),
                .en      (accept),
                .addr    (col_cnt),
                .wr_data (lb_wr[i]),
                .rd_data (lb_rd[i])
            );
        end
    endgenerate

    // Next window: shift every row left, oldest row on top takes the oldest buffer.
    always_comb begin
        win_nxt = win;
        for (int k = 0; k < KY; k++) begin
            for (int j = 0; j < KX - 1; j++) begin
                win_nxt[k][j] = win[k][j+1];
            end
        end
        for (int k = 0; k < KY - 1; k++) begin
            win_nxt[k][KX-1] = lb_rd[KY-2-k];
        end
        win_nxt[KY-1][KX-1] = i_in_pixel;
    end

    // Flatten the next window in the consumer's element order.
    always_comb begin
        fmap_nxt = '0;
        for (int k = 0; k < KY; k++) begin
            for (int j = 0; j < KX; j++) begin
                fmap_nxt[idx(k, j, KX)*I_F_BW +: I_F_BW] = win_nxt[k][j];
            end
        end
    end

    // Position counters, window registers and the registered output strobe/data.
    always_ff @(posedge clk) begin
        if (reset) begin
            col_cnt         <= '0;
            row_cnt         <= '0;
            o_ot_valid      <= 1'b0;
            o_ot_frame_done <= 1'b0;
            o_ot_fmap       <= '0;
            for (int k = 0; k < KY; k++) begin
                for (int j = 0; j < KX; j++) begin
                    win[k][j] <= '0;
                end
            end
        end else begin
            o_ot_valid      <= i_in_valid && emit;
            o_ot_frame_done <= i_in_valid && emit && last_px;
            if (i_in_valid) begin
                win <= win_nxt;
                if (emit) begin
                    o_ot_fmap <= fmap_nxt;
                end
                if (col_wrap) begin
                    col_cnt <= '0;
                    row_cnt <= (row_cnt == ROW_LAST) ? '0 : row_cnt + 1'b1;
                end else begin
                    col_cnt <= col_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cnn_window_gen.sv
// Directed bench for cnn_window_gen: a small 6x6 / 3x3 instance for the
// scenario tests and a default-size instance fed with random pixels.
module tb_cnn_window_gen;
    import cnn_pkg::*;

    localparam int SW  = 6;
    localparam int SH  = 6;
    localparam int SK  = 3;
    localparam int BW  = 8;
    localparam int SFW = SK * SK * BW;
    localparam int LFW = DEF_KX * DEF_KY * DEF_I_F_BW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           s_reset, s_valid, s_ot_valid, s_done;
    logic [BW-1:0]  s_pixel;
    logic [SFW-1:0] s_fmap;
    logic           l_reset, l_valid, l_ot_valid, l_done;
    logic [DEF_I_F_BW-1:0] l_pixel;
    logic [LFW-1:0] l_fmap;

    int errors = 0;
    int checks = 0;
    logic [SFW-1:0] s_exp_fmap;
    int img [DEF_IMG_H][DEF_IMG_W];

    cnn_window_gen #(
        .IMG_W (SW), .IMG_H (SH), .KX (SK), .KY (SK), .I_F_BW (BW)
    ) u_small (
        .clk             (clk),
        .reset           (s_reset),
        .i_in_valid      (s_valid),
        .i_in_pixel      (s_pixel),
        .o_ot_valid      (s_ot_valid),
        .o_ot_fmap       (s_fmap),
        .o_ot_frame_done (s_done)
    );

    cnn_window_gen u_def (
        .clk             (clk),
        .reset           (l_reset),
        .i_in_valid      (l_valid),
        .i_in_pixel      (l_pixel),
        .o_ot_valid      (l_ot_valid),
        .o_ot_fmap       (l_fmap),
        .o_ot_frame_done (l_done)
    );

    task automatic applyStimulus(input logic rst, input logic vld, input int pix);
        s_reset = rst;
        s_valid = vld;
        s_pixel = pix[7:0];
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulusDef(input logic rst, input logic vld, input int pix);
        l_reset = rst;
        l_valid = vld;
        l_pixel = pix[7:0];
        @(posedge clk);
        #1;
    endtask

    function automatic logic [SFW-1:0] small_window(input int base, input int r, input int c);
        logic [SFW-1:0] w;
        w = '0;
        for (int k = 0; k < SK; k++)
            for (int j = 0; j < SK; j++)
                w[(k*SK+j)*BW +: BW] = 8'(base + (r - SK + 1 + k) * SW + (c - SK + 1 + j));
        return w;
    endfunction

    task automatic reset_small();
        applyStimulus(1'b1, 1'b0, 0);
        applyStimulus(1'b1, 1'b0, 0);
        s_exp_fmap = '0;
    endtask

    // One full small frame, pixel = base + r*6 + c, optionally with an idle cycle after each pixel.
    task automatic stream_frame_small(input int base, input bit toggle, output int nwin);
        bit ev, ed;
        nwin = 0;
        for (int r = 0; r < SH; r++) begin
            for (int c = 0; c < SW; c++) begin
                ev = (r >= SK - 1) && (c >= SK - 1);
                ed = (r == SH - 1) && (c == SW - 1);
                applyStimulus(1'b0, 1'b1, base + r * SW + c);
                if (ev) s_exp_fmap = small_window(base, r, c);
                checks++;
                if (s_ot_valid !== ev) begin
                    errors++;
                    $display("[TB] FAIL valid r=%0d c=%0d: got %b expected %b", r, c, s_ot_valid, ev);
                end
                checks++;
                if (s_fmap !== s_exp_fmap) begin
                    errors++;
                    $display("[TB] FAIL fmap r=%0d c=%0d: got %h expected %h", r, c, s_fmap, s_exp_fmap);
                end
                checks++;
                if (s_done !== ed) begin
                    errors++;
                    $display("[TB] FAIL frame_done r=%0d c=%0d: got %b expected %b", r, c, s_done, ed);
                end
                if (s_ot_valid === 1'b1) nwin++;
                if (toggle) begin
                    applyStimulus(1'b0, 1'b0, 8'hEE);
                    checks++;
                    if (s_ot_valid !== 1'b0 || s_done !== 1'b0) begin
                        errors++;
                        $display("[TB] FAIL idle_strobe r=%0d c=%0d: got %b/%b expected 0/0", r, c, s_ot_valid, s_done);
                    end
                    checks++;
                    if (s_fmap !== s_exp_fmap) begin
                        errors++;
                        $display("[TB] FAIL idle_hold r=%0d c=%0d: got %h expected %h", r, c, s_fmap, s_exp_fmap);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        l_reset = 1'b1; l_valid = 1'b0; l_pixel = '0;
        reset_small();
        checks++;
        if (s_ot_valid !== 1'b0 || s_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_small_strobes: got %b/%b expected 0/0", s_ot_valid, s_done);
        end
        checks++;
        if (s_fmap !== '0) begin
            errors++;
            $display("[TB] FAIL reset_small_fmap: got %h expected 0", s_fmap);
        end
        checks++;
        if (l_ot_valid !== 1'b0 || l_done !== 1'b0 || l_fmap !== '0) begin
            errors++;
            $display("[TB] FAIL reset_def: got %b/%b/%h expected 0/0/0", l_ot_valid, l_done, l_fmap);
        end
        l_reset = 1'b0;
    endtask

    task automatic test_continuous();
        int n;
        reset_small();
        stream_frame_small(0, 1'b0, n);
        checks++;
        if (n != 16) begin
            errors++;
            $display("[TB] FAIL continuous_count: got %0d expected 16", n);
        end
    endtask

    task automatic test_toggle_valid();
        int n;
        reset_small();
        stream_frame_small(0, 1'b1, n);
        checks++;
        if (n != 16) begin
            errors++;
            $display("[TB] FAIL toggle_count: got %0d expected 16", n);
        end
    endtask

    task automatic test_back_to_back();
        int n1, n2;
        reset_small();
        stream_frame_small(0, 1'b0, n1);
        stream_frame_small(100, 1'b0, n2);
        checks++;
        if (n1 != 16 || n2 != 16) begin
            errors++;
            $display("[TB] FAIL b2b_count: got %0d/%0d expected 16/16", n1, n2);
        end
    endtask

    task automatic test_reset_mid_frame();
        int n;
        reset_small();
        for (int p = 0; p <= 20; p++) applyStimulus(1'b0, 1'b1, p);
        applyStimulus(1'b1, 1'b0, 0);
        s_exp_fmap = '0;
        checks++;
        if (s_ot_valid !== 1'b0 || s_fmap !== '0) begin
            errors++;
            $display("[TB] FAIL midreset_out: got %b/%h expected 0/0", s_ot_valid, s_fmap);
        end
        stream_frame_small(0, 1'b0, n);
        checks++;
        if (n != 16) begin
            errors++;
            $display("[TB] FAIL midreset_count: got %0d expected 16", n);
        end
    endtask

    task automatic test_reset_priority();
        int n;
        reset_small();
        for (int p = 0; p <= 16; p++) applyStimulus(1'b0, 1'b1, p);
        applyStimulus(1'b1, 1'b1, 99);
        s_exp_fmap = '0;
        checks++;
        if (s_ot_valid !== 1'b0 || s_done !== 1'b0 || s_fmap !== '0) begin
            errors++;
            $display("[TB] FAIL priority_out: got %b/%b/%h expected 0/0/0", s_ot_valid, s_done, s_fmap);
        end
        stream_frame_small(0, 1'b0, n);
        checks++;
        if (n != 16) begin
            errors++;
            $display("[TB] FAIL priority_count: got %0d expected 16", n);
        end
    endtask

    task automatic test_defaults_random();
        int nwin, ndone;
        bit ev, ed;
        logic [LFW-1:0] exp_f;
        for (int r = 0; r < DEF_IMG_H; r++)
            for (int c = 0; c < DEF_IMG_W; c++)
                img[r][c] = int'($urandom_range(0, 255));
        applyStimulusDef(1'b1, 1'b0, 0);
        exp_f = '0;
        nwin = 0;
        ndone = 0;
        for (int r = 0; r < DEF_IMG_H; r++) begin
            for (int c = 0; c < DEF_IMG_W; c++) begin
                ev = (r >= DEF_KY - 1) && (c >= DEF_KX - 1);
                ed = (r == DEF_IMG_H - 1) && (c == DEF_IMG_W - 1);
                applyStimulusDef(1'b0, 1'b1, img[r][c]);
                if (ev)
                    for (int k = 0; k < DEF_KY; k++)
                        for (int j = 0; j < DEF_KX; j++)
                            exp_f[(k*DEF_KX+j)*DEF_I_F_BW +: DEF_I_F_BW] =
                                8'(img[r-DEF_KY+1+k][c-DEF_KX+1+j]);
                checks++;
                if (l_ot_valid !== ev || l_done !== ed) begin
                    errors++;
                    $display("[TB] FAIL def_strobes r=%0d c=%0d: got %b/%b expected %b/%b",
                             r, c, l_ot_valid, l_done, ev, ed);
                end
                checks++;
                if (l_fmap !== exp_f) begin
                    errors++;
                    $display("[TB] FAIL def_fmap r=%0d c=%0d: got %h expected %h", r, c, l_fmap, exp_f);
                end
                if (l_ot_valid === 1'b1) nwin++;
                if (l_done === 1'b1) ndone++;
            end
        end
        l_valid = 1'b0;
        checks++;
        if (nwin != WIN_PER_FRAME || ndone != 1) begin
            errors++;
            $display("[TB] FAIL def_counts: got %0d/%0d expected %0d/1", nwin, ndone, WIN_PER_FRAME);
        end
    endtask

    initial begin
        s_reset = 1'b1; s_valid = 1'b0; s_pixel = '0;
        l_reset = 1'b1; l_valid = 1'b0; l_pixel = '0;
        s_exp_fmap = '0;
        test_reset();
        test_continuous();
        test_toggle_valid();
        test_back_to_back();
        test_reset_mid_frame();
        test_reset_priority();
        test_defaults_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cnn_window_gen.md
Name: cnn_window_gen

Overview:
- Producer side of the convolution kernel's window interface.
- Accepts a raster-order pixel stream, one pixel per valid cycle, and buffers KY-1 image lines.
- Emits the KX x KY sliding window (stride 1, no padding) as one flattened bus with a valid strobe.
- Output feeds the kernel's i_in_valid / i_in_fmap directly; the flattening order matches that interface.

Parameters:
- IMG_W, 28, image width in pixels.
- IMG_H, 28, image height in pixels.
- KX, 5, window width.
- KY, 5, window height.
- I_F_BW, 8, pixel bit width (unsigned).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- i_in_valid  in  1  pixel strobe; pixel accepted on every clk edge where high.
- i_in_pixel  in  I_F_BW  pixel data, raster order (row-major, col 0 first).
- o_ot_valid  out  1  window valid, 1-cycle pulse per window.
- o_ot_fmap  out  KX*KY*I_F_BW  window; element (k,j) at bits [(k*KX+j)*I_F_BW +: I_F_BW]; k=0 top (oldest) row, j=0 leftmost column.
- o_ot_frame_done  out  1  pulses together with the last window of a frame.

Behaviour:
- Reset (clk edge with reset=1):
  - o_ot_valid=0, o_ot_frame_done=0, o_ot_fmap=0.
  - col/row counters=0; window registers=0.
  - Line-buffer contents are not cleared.
- No backpressure; the consumer always accepts.
- Cycles with i_in_valid=0 change nothing: counters, line buffers and window hold; o_ot_valid=0 in the following cycle.
- Per accepted pixel at (row r, col c):
  - Each window row shifts left by one.
  - New right column is the column-c values from line buffers (rows r-KY+1..r-1) plus i_in_pixel.
  - Line buffers are updated at column c.
  - c increments; at c=IMG_W-1 it wraps to 0 and r increments; at r=IMG_H-1, c=IMG_W-1 both wrap to 0 (next frame begins; no frame-start input).
- Emit rule:
  - o_ot_valid=1 in the cycle after accepting (r,c) iff r>=KY-1 and c>=KX-1.
  - Window contents = pixels rows r-KY+1..r, cols c-KX+1..c.
  - Latency: 1 clk from the bottom-right pixel to valid.
- Windows never straddle a row wrap; columns c<KX-1 emit nothing.
- Windows per frame = (IMG_W-KX+1)*(IMG_H-KY+1); 576 at defaults.
- o_ot_frame_done=1 exactly with the window for (IMG_H-1, IMG_W-1).
- o_ot_fmap holds its last value when o_ot_valid=0.
- Back-to-back frames:
  - No bubble required.
  - Rows 0..KY-2 of the new frame emit nothing, so stale line data never appears in a valid window.
- Reset mid-frame: the next accepted pixel is treated as (0,0); no window emits until KY-1 full lines plus KX pixels are accepted again.
- Reset has priority over i_in_valid in the same cycle.
- Storage: KY-1 line buffers of IMG_W x I_F_BW (inferable as RAM or shift register); KY x KX window registers.
- Counter widths: clog2(IMG_W) and clog2(IMG_H).

Decomposition:
- Shared package cnn_pkg:
  - Default IMG_W/IMG_H/KX/KY/I_F_BW.
  - Window element index function idx(k,j)=k*KX+j.
  - Derived localparams: windows-per-frame, counter widths.
- Sub-module cnn_line_buffer: one IMG_W-deep, I_F_BW-wide line; read-then-write at the same column index on an enable; instantiated KY-1 times in a generate loop.

Test Plan:
- IMG_W=IMG_H=6, KX=KY=3, pixel=r*6+c, continuous valid -> first o_ot_valid the cycle after pixel 14; fmap elements 0..8 = 0,1,2,6,7,8,12,13,14; 16 windows total; o_ot_frame_done only with the window ending at 35 (elements 21,22,23,27,28,29,33,34,35).
- Same stream with i_in_valid toggling 1-0-1-0 -> identical window sequence and values; each valid pulse lands 1 cycle after its bottom-right pixel.
- Two frames back-to-back, frame 2 pixel=100+r*6+c -> 16 windows each; frame 2's first window is 100,101,102,106,107,108,112,113,114; no frame-1 data appears.
- Reset asserted after pixel 20, then a fresh frame -> no valid until 15 pixels accepted; first window is 0,1,2,6,7,8,12,13,14.
- Defaults 28x28, 5x5, random pixels -> 576 windows, each matching the reference-model 5x5 crop; 1 frame_done.
- reset and i_in_valid both high in one cycle -> pixel dropped; outputs 0 next cycle.
